pipe_ctrl: RTL and testbench

PIPE_CTRL -- requirements
Module: pipe_ctrl

---
 rtl/pipe_ctrl.sv | 123 ++++++++++++
 tb/tb_pipe_ctrl.sv | 247 ++++++++++++++++++++++++
 2 files changed

// File: rtl/pipe_ctrl.sv
// Pipeline hazard controller: turns EX jump, EX busy and ID load-use indications
// into PC redirect, stall and flush controls, with a saturating stall-cycle counter.
module pipe_ctrl #(
  parameter int FLUSH_CYCLES = 2,
  parameter int LOAD_STALL   = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        jump_flag_i,
  input  logic [31:0] jump_addr_i,
  input  logic        hold_ex_i,
  input  logic        load_use_i,
  output logic        jump_flag_o,
  output logic [31:0] jump_addr_o,
  output logic        stall_pc_o,
  output logic        stall_if_id_o,
  output logic        stall_id_ex_o,
  output logic        flush_if_id_o,
  output logic        flush_id_ex_o,
  output logic [1:0]  state_o,
  output logic [15:0] stall_cnt_o
);

  typedef enum logic [1:0] {
    RUN   = 2'd0,
    FLUSH = 2'd1,
    HOLD  = 2'd2,
    STALL = 2'd3
  } state_t;

  localparam logic [3:0] FLUSH_INIT = 4'(FLUSH_CYCLES - 1);
  localparam logic [3:0] STALL_INIT = 4'(LOAD_STALL - 1);

  state_t      state;
  logic [3:0]  cnt;
  logic [15:0] stall_cnt;

  assign state_o     = state;
  assign stall_cnt_o = stall_cnt;

  // Controls are combinational so a hazard seen this cycle acts this cycle.
  always_comb begin
    jump_flag_o   = 1'b0;
    jump_addr_o   = 32'd0;
    stall_pc_o    = 1'b0;
    stall_if_id_o = 1'b0;
    stall_id_ex_o = 1'b0;
    flush_if_id_o = 1'b0;
    flush_id_ex_o = 1'b0;
    if (rst) begin
      if (jump_flag_i) begin
        jump_flag_o   = 1'b1;
        jump_addr_o   = jump_addr_i;
        flush_if_id_o = 1'b1;
        flush_id_ex_o = 1'b1;
      end else if (state == FLUSH) begin
        flush_if_id_o = 1'b1;
        flush_id_ex_o = 1'b1;
      end else if (hold_ex_i) begin
        stall_pc_o    = 1'b1;
        stall_if_id_o = 1'b1;
        stall_id_ex_o = 1'b1;
      end else if (load_use_i || state == STALL) begin
        stall_pc_o    = 1'b1;
        stall_if_id_o = 1'b1;
        flush_id_ex_o = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state     <= RUN;
      cnt       <= 4'd0;
      stall_cnt <= 16'd0;
    end else begin
      if (stall_pc_o && stall_cnt != 16'hFFFF) begin
        stall_cnt <= stall_cnt + 16'd1;
      end
      if (jump_flag_i) begin
        // A taken jump cancels whatever count was pending.
        state <= (FLUSH_CYCLES > 1) ? FLUSH : RUN;
        cnt   <= (FLUSH_CYCLES > 1) ? FLUSH_INIT : 4'd0;
      end else begin
        case (state)
          FLUSH: begin
            if (cnt <= 4'd1) begin
              state <= RUN;
              cnt   <= 4'd0;
            end else begin
              cnt <= cnt - 4'd1;
            end
          end
          STALL: begin
            if (hold_ex_i) begin
              state <= HOLD;
              cnt   <= 4'd0;
            end else if (cnt <= 4'd1) begin
              state <= RUN;
              cnt   <= 4'd0;
            end else begin
              cnt <= cnt - 4'd1;
            end
          end
          default: begin
            // RUN and HOLD share rules: HOLD with hold_ex_i low behaves as RUN.
            if (hold_ex_i) begin
              state <= HOLD;
              cnt   <= 4'd0;
            end else if (load_use_i && LOAD_STALL > 1) begin
              state <= STALL;
              cnt   <= STALL_INIT;
            end else begin
              state <= RUN;
              cnt   <= 4'd0;
            end
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_pipe_ctrl.sv
// Bench for pipe_ctrl: per-cycle scoreboard against a reference model plus
// directed checks for jump, hold, load-use, priority, reset and saturation.
module tb_pipe_ctrl;

  localparam int FLUSH_CYCLES = 2;
  localparam int LOAD_STALL   = 3;

  logic        clk;
  logic        rst;
  logic        jump_flag_i;
  logic [31:0] jump_addr_i;
  logic        hold_ex_i;
  logic        load_use_i;
  logic        jump_flag_o;
  logic [31:0] jump_addr_o;
  logic        stall_pc_o;
  logic        stall_if_id_o;
  logic        stall_id_ex_o;
  logic        flush_if_id_o;
  logic        flush_id_ex_o;
  logic [1:0]  state_o;
  logic [15:0] stall_cnt_o;

  pipe_ctrl #(
    .FLUSH_CYCLES(FLUSH_CYCLES),
    .LOAD_STALL  (LOAD_STALL)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .jump_flag_i  (jump_flag_i),
    .jump_addr_i  (jump_addr_i),
    .hold_ex_i    (hold_ex_i),
    .load_use_i   (load_use_i),
    .jump_flag_o  (jump_flag_o),
    .jump_addr_o  (jump_addr_o),
    .stall_pc_o   (stall_pc_o),
    .stall_if_id_o(stall_if_id_o),
    .stall_id_ex_o(stall_id_ex_o),
    .flush_if_id_o(flush_if_id_o),
    .flush_id_ex_o(flush_id_ex_o),
    .state_o      (state_o),
    .stall_cnt_o  (stall_cnt_o)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- scoreboard ----------------
  int n_checks = 0;
  int n_fail   = 0;
  logic [55:0] exp_q[$];
  logic [55:0] obs_v;

  assign obs_v = {jump_flag_o, jump_addr_o, stall_pc_o, stall_if_id_o, stall_id_ex_o,
                  flush_if_id_o, flush_id_ex_o, state_o, stall_cnt_o};

  task automatic check_eq(input string tag, input logic [55:0] obs, input logic [55:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  always @(negedge clk) begin
    logic [55:0] e;
    #1;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      check_eq("cycle_vec", obs_v, e);
    end
  end

  // ---------------- reference model ----------------
  // m_state is the architectural state, m_left the cycles still owed in FLUSH/STALL.
  logic [1:0]  m_state = 2'd0;
  int          m_left  = 0;
  logic [15:0] m_scnt  = 16'd0;

  task automatic model_step(input logic jf, input logic [31:0] ja, input logic hold,
                            input logic lu, input logic rn, output logic [55:0] ev);
    logic        o_jf, s_pc, s_ifid, s_idex, f_ifid, f_idex;
    logic [31:0] o_ja;
    o_jf = 0; o_ja = 32'd0; s_pc = 0; s_ifid = 0; s_idex = 0; f_ifid = 0; f_idex = 0;
    if (rn) begin
      if (jf) begin
        o_jf = 1; o_ja = ja; f_ifid = 1; f_idex = 1;
      end else if (m_state == 2'd1) begin
        f_ifid = 1; f_idex = 1;
      end else if (hold) begin
        s_pc = 1; s_ifid = 1; s_idex = 1;
      end else if (lu || m_state == 2'd3) begin
        s_pc = 1; s_ifid = 1; f_idex = 1;
      end
    end
    ev = {o_jf, o_ja, s_pc, s_ifid, s_idex, f_ifid, f_idex, m_state, m_scnt};
    if (!rn) begin
      m_state = 2'd0; m_left = 0; m_scnt = 16'd0;
    end else begin
      if (s_pc && m_scnt != 16'hFFFF) m_scnt = m_scnt + 16'd1;
      if (jf) begin
        m_left  = FLUSH_CYCLES - 1;
        m_state = (m_left > 0) ? 2'd1 : 2'd0;
      end else if (m_state == 2'd1) begin
        m_left--;
        if (m_left <= 0) begin m_state = 2'd0; m_left = 0; end
      end else if (hold) begin
        m_state = 2'd2; m_left = 0;
      end else if (m_state == 2'd3) begin
        m_left--;
        if (m_left <= 0) begin m_state = 2'd0; m_left = 0; end
      end else if (lu) begin
        m_left  = LOAD_STALL - 1;
        m_state = (m_left > 0) ? 2'd3 : 2'd0;
      end else begin
        m_state = 2'd0;
      end
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic drive(input logic jf, input logic [31:0] ja, input logic hold,
                       input logic lu, input logic rn);
    logic [55:0] ev;
    @(negedge clk);
    jump_flag_i = jf;
    jump_addr_i = ja;
    hold_ex_i   = hold;
    load_use_i  = lu;
    rst         = rn;
    model_step(jf, ja, hold, lu, rn, ev);
    exp_q.push_back(ev);
  endtask

  task automatic idle();
    drive(1'b0, 32'd0, 1'b0, 1'b0, 1'b1);
  endtask

  // Lets the DUT settle after a drive, still well before the next rising edge.
  task automatic settle();
    #2;
  endtask

  // ---------------- test sequence ----------------
  initial begin
    int n_a, n_b;
    logic [15:0] base;
    rst = 1'b0; jump_flag_i = 1'b0; jump_addr_i = 32'd0; hold_ex_i = 1'b0; load_use_i = 1'b0;
    repeat (2) @(posedge clk);

    // Reset state, with inputs active that reset must mask.
    drive(1'b1, 32'hDEAD_BEEF, 1'b1, 1'b1, 1'b0);
    settle();
    check_eq("rst_state", 56'(state_o), 56'd0);
    check_eq("rst_jump_masked", 56'(jump_flag_o), 56'd0);
    check_eq("rst_addr_masked", 56'(jump_addr_o), 56'd0);
    check_eq("rst_stall_cnt", 56'(stall_cnt_o), 56'd0);
    idle(); idle();

    // Jump in RUN: flush two cycles, RUN on the third.
    drive(1'b1, 32'h0000_0100, 1'b0, 1'b0, 1'b1);
    settle();
    check_eq("jmp_flag", 56'(jump_flag_o), 56'd1);
    check_eq("jmp_addr", 56'(jump_addr_o), 56'h100);
    check_eq("jmp_flush1", 56'({flush_if_id_o, flush_id_ex_o}), 56'd3);
    idle(); settle();
    check_eq("jmp_flush2", 56'({flush_if_id_o, flush_id_ex_o}), 56'd3);
    check_eq("jmp_state_flush", 56'(state_o), 56'd1);
    check_eq("jmp_addr_zero", 56'(jump_addr_o), 56'd0);
    idle(); settle();
    check_eq("jmp_flush_done", 56'({flush_if_id_o, flush_id_ex_o}), 56'd0);
    check_eq("jmp_state_run", 56'(state_o), 56'd0);

    // Hold for 5 cycles.
    n_a = 0;
    for (int i = 0; i < 5; i++) begin
      drive(1'b0, 32'd0, 1'b1, 1'b0, 1'b1);
      settle();
      if (stall_pc_o && stall_if_id_o && stall_id_ex_o) n_a++;
    end
    idle(); settle();
    check_eq("hold_release", 56'({stall_pc_o, stall_if_id_o, stall_id_ex_o}), 56'd0);
    check_eq("hold_cycles", 56'(n_a), 56'd5);
    check_eq("hold_stall_cnt", 56'(stall_cnt_o), 56'd5);
    idle(); settle();
    check_eq("hold_state_after", 56'(state_o), 56'd0);

    // One-cycle load-use with LOAD_STALL=3.
    base = stall_cnt_o;
    n_a = 0; n_b = 0;
    drive(1'b0, 32'd0, 1'b0, 1'b1, 1'b1);
    settle();
    n_a += int'(stall_pc_o); n_b += int'(flush_id_ex_o);
    for (int i = 0; i < 3; i++) begin
      idle(); settle();
      n_a += int'(stall_pc_o); n_b += int'(flush_id_ex_o);
    end
    check_eq("lu_stall_cycles", 56'(n_a), 56'd3);
    check_eq("lu_bubble_cycles", 56'(n_b), 56'd3);
    check_eq("lu_stall_cnt", 56'(stall_cnt_o - base), 56'd3);

    // Jump and hold in the same cycle: jump wins.
    drive(1'b1, 32'h0000_2000, 1'b1, 1'b0, 1'b1);
    settle();
    check_eq("prio_jump", 56'(jump_flag_o), 56'd1);
    check_eq("prio_no_stall", 56'({stall_pc_o, stall_if_id_o, stall_id_ex_o}), 56'd0);
    idle(); settle();
    check_eq("prio_state_flush", 56'(state_o), 56'd1);
    idle(); idle();

    // Random traffic, scoreboard only.
    for (int i = 0; i < 400; i++) begin
      drive($urandom_range(0, 9) == 0, $urandom(), $urandom_range(0, 3) == 0,
            $urandom_range(0, 2) == 0, $urandom_range(0, 39) != 0);
    end
    idle(); idle(); idle(); idle();

    // Reset in the middle of HOLD.
    for (int i = 0; i < 3; i++) drive(1'b0, 32'd0, 1'b1, 1'b0, 1'b1);
    settle();
    check_eq("mid_hold_state", 56'(state_o), 56'd2);
    drive(1'b0, 32'd0, 1'b1, 1'b0, 1'b0);
    settle();
    check_eq("mid_hold_rst_outs", 56'({stall_pc_o, stall_if_id_o, stall_id_ex_o}), 56'd0);
    idle(); settle();
    check_eq("post_rst_state", 56'(state_o), 56'd0);
    check_eq("post_rst_stall_cnt", 56'(stall_cnt_o), 56'd0);
    check_eq("post_rst_outs", 56'({jump_flag_o, stall_pc_o, stall_if_id_o, stall_id_ex_o,
                                   flush_if_id_o, flush_id_ex_o}), 56'd0);

    // Long hold: counter saturates.
    for (int i = 0; i < 70000; i++) drive(1'b0, 32'd0, 1'b1, 1'b0, 1'b1);
    settle();
    check_eq("sat_stall_cnt", 56'(stall_cnt_o), 56'hFFFF);
    idle(); settle();
    check_eq("sat_hold_after", 56'(stall_cnt_o), 56'hFFFF);
    idle();

    @(negedge clk);
    #3;
    if (exp_q.size() != 0) check_eq("queue_drained", 56'(exp_q.size()), 56'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_checks, n_fail);
    $finish;
  end

endmodule
